// File: rtl/sel_mux_pipe.sv
// sel_mux_pipe: registered N-way channel selector with a valid/ready handshake.
// A word is accepted when in_valid && in_ready. The selected channel appears on
// out_data one cycle later. Out-of-range selects are dropped and pulse sel_err.
// Optional feature: define SEL_MUX_ERRCNT_EN to add the saturating 8-bit err_cnt
// port, which counts dropped selects.
module sel_mux_pipe #(
   parameter int WIDTH = 32,
   parameter int NCH   = 6,
   parameter int SELW  = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NCH*WIDTH-1:0]   d_in,
   input  logic [SELW-1:0]        sel,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   sel_err
`ifdef SEL_MUX_ERRCNT_EN
   ,
   output logic [7:0]             err_cnt
`endif
);

   logic                   r_vld_p1;
   logic signed [WIDTH-1:0] r_data_p1;
   logic                   r_sel_err_p1;
   logic signed [WIDTH-1:0] w_chan;
   logic                   w_sel_ok;
   logic                   w_xfer;
   logic                   w_take;
   logic                   w_drop;
   logic                   w_consume;

   // The output register can take a new word when it is empty or is being drained.
   assign in_ready  = !r_vld_p1 || out_ready;
   assign w_xfer    = in_valid && in_ready;
   assign w_sel_ok  = (32'(sel) < NCH);
   assign w_take    = w_xfer && w_sel_ok;
   assign w_drop    = w_xfer && !w_sel_ok;
   assign w_consume = r_vld_p1 && out_ready;

   // Channel select. An out-of-range index matches no channel, so the mux
   // resolves to zero and never produces an undefined value.
   always_comb begin
      w_chan = '0;
      for (int k = 0; k < NCH; k++) begin
         if (sel == SELW'(k)) begin
            w_chan = d_in[k*WIDTH +: WIDTH];
         end
      end
   end

   // ---- stage p0 -> p1: output data register, loads only on an accepted in-range word
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_data_p1 <= '0;
      end else if (w_take) begin
         r_data_p1 <= w_chan;
      end
   end

   // Output valid: a transfer decides it outright. A dropped word leaves the
   // register empty because the previous word is necessarily consumed in that cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld_p1 <= 1'b0;
      end else if (w_xfer) begin
         r_vld_p1 <= w_sel_ok;
      end else if (w_consume) begin
         r_vld_p1 <= 1'b0;
      end
   end

   // One-cycle error pulse following a dropped select.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sel_err_p1 <= 1'b0;
      end else begin
         r_sel_err_p1 <= w_drop;
      end
   end

`ifdef SEL_MUX_ERRCNT_EN
   logic [7:0] r_err_cnt;

   function automatic logic [7:0] f_sat_inc(input logic [7:0] a);
      if (a == 8'hFF) begin
         return a;
      end
      return a + 8'd1;
   endfunction

   // Saturating count of dropped selects; only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err_cnt <= '0;
      end else if (w_drop) begin
         r_err_cnt <= f_sat_inc(r_err_cnt);
      end
   end

   assign err_cnt = r_err_cnt;
`endif

   assign out_data  = r_data_p1;
   assign out_valid = r_vld_p1;
   assign sel_err   = r_sel_err_p1;

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Directed bench for sel_mux_pipe: a default-parameter instance (6 x 32-bit)
// and a narrow instance (3 x 8-bit, 2-bit select) sharing clock and reset.
module tb_sel_mux_pipe;

   logic         clk = 1'b0;
   logic         rst_n;

   logic [191:0] d_in_a;
   logic [2:0]   sel_a;
   logic         in_valid_a;
   logic         in_ready_a;
   logic [31:0]  out_data_a;
   logic         out_valid_a;
   logic         out_ready_a;
   logic         sel_err_a;

   logic [23:0]  d_in_b;
   logic [1:0]   sel_b;
   logic         in_valid_b;
   logic         in_ready_b;
   logic [7:0]   out_data_b;
   logic         out_valid_b;
   logic         out_ready_b;
   logic         sel_err_b;

`ifdef SEL_MUX_ERRCNT_EN
   logic [7:0]   err_cnt_a;
   logic [7:0]   err_cnt_b;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sel_mux_pipe #(.WIDTH(32), .NCH(6), .SELW(3)) u_a (
      .clk(clk), .rst_n(rst_n), .d_in(d_in_a), .sel(sel_a),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .out_data(out_data_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .sel_err(sel_err_a)
`ifdef SEL_MUX_ERRCNT_EN
      , .err_cnt(err_cnt_a)
`endif
   );

   sel_mux_pipe #(.WIDTH(8), .NCH(3), .SELW(2)) u_b (
      .clk(clk), .rst_n(rst_n), .d_in(d_in_b), .sel(sel_b),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .out_data(out_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .sel_err(sel_err_b)
`ifdef SEL_MUX_ERRCNT_EN
      , .err_cnt(err_cnt_b)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      int vld_seen;
      rst_n       = 1'b0;
      in_valid_a  = 1'b0;
      out_ready_a = 1'b0;
      sel_a       = 3'd0;
      in_valid_b  = 1'b0;
      out_ready_b = 1'b0;
      sel_b       = 2'd0;
      for (int k = 0; k < 6; k++) d_in_a[k*32 +: 32] = 32'h1000_0000 + 32'(k);
      for (int k = 0; k < 3; k++) d_in_b[k*8 +: 8] = 8'hA0 + 8'(k);

      // Reset state
      tick();
      tick();
      chk1 ("rst_out_valid", out_valid_a, 1'b0);
      chk32("rst_out_data",  out_data_a,  32'h0);
      chk1 ("rst_sel_err",   sel_err_a,   1'b0);
`ifdef SEL_MUX_ERRCNT_EN
      chk8 ("rst_err_cnt",   err_cnt_a,   8'd0);
`endif
      rst_n = 1'b1;
      #1;
      chk1 ("post_rst_in_ready", in_ready_a, 1'b1);

      // Streaming sel 0..5 at full rate
      out_ready_a = 1'b1;
      in_valid_a  = 1'b1;
      for (int s = 0; s < 6; s++) begin
         sel_a = 3'(s);
         tick();
         chk32("stream_data",  out_data_a,  32'h1000_0000 + 32'(s));
         chk1 ("stream_valid", out_valid_a, 1'b1);
         chk1 ("stream_err",   sel_err_a,   1'b0);
      end
      in_valid_a = 1'b0;
      tick();
      chk1 ("drain_valid", out_valid_a, 1'b0);
      chk32("drain_hold",  out_data_a,  32'h1000_0005);

      // Back-pressure
      in_valid_a = 1'b1;
      sel_a      = 3'd2;
      tick();
      chk32("bp_first", out_data_a, 32'h1000_0002);
      out_ready_a = 1'b0;
      sel_a       = 3'd4;
      #1;
      chk1 ("bp_in_ready0", in_ready_a, 1'b0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk32("bp_hold_data",  out_data_a,  32'h1000_0002);
         chk1 ("bp_hold_valid", out_valid_a, 1'b1);
         chk1 ("bp_hold_ready", in_ready_a,  1'b0);
      end
      out_ready_a = 1'b1;
      #1;
      chk1 ("bp_release_ready", in_ready_a, 1'b1);
      tick();
      chk32("bp_deliver_data",  out_data_a,  32'h1000_0004);
      chk1 ("bp_deliver_valid", out_valid_a, 1'b1);
      in_valid_a = 1'b0;
      tick();
      chk1 ("bp_consumed", out_valid_a, 1'b0);

      // Out-of-range selects 6 and 7
      in_valid_a = 1'b1;
      sel_a      = 3'd6;
      tick();
      chk1 ("oor6_err",   sel_err_a,   1'b1);
      chk1 ("oor6_valid", out_valid_a, 1'b0);
      chk32("oor6_data",  out_data_a,  32'h1000_0004);
      sel_a = 3'd7;
      tick();
      chk1 ("oor7_err",   sel_err_a,   1'b1);
      chk1 ("oor7_valid", out_valid_a, 1'b0);
      chk32("oor7_data",  out_data_a,  32'h1000_0004);
      in_valid_a = 1'b0;
      tick();
      chk1 ("oor_err_clear", sel_err_a, 1'b0);
`ifdef SEL_MUX_ERRCNT_EN
      chk8 ("oor_err_cnt", err_cnt_a, 8'd2);
`endif

      // Valid word followed immediately by a drop: word consumed, register empties
      sel_a      = 3'd1;
      in_valid_a = 1'b1;
      tick();
      chk1 ("mix_valid", out_valid_a, 1'b1);
      sel_a = 3'd6;
      tick();
      chk1 ("mix_drop_valid", out_valid_a, 1'b0);
      chk32("mix_drop_data",  out_data_a,  32'h1000_0001);

      // 300 out-of-range selects: counter saturates, output never becomes valid
      vld_seen = 0;
      sel_a    = 3'd7;
      for (int c = 0; c < 300; c++) begin
         tick();
         if (out_valid_a !== 1'b0) vld_seen++;
      end
      in_valid_a = 1'b0;
      tick();
      chk32("sat_no_valid", 32'(vld_seen), 32'd0);
      chk1 ("sat_valid_now", out_valid_a, 1'b0);
`ifdef SEL_MUX_ERRCNT_EN
      chk8 ("sat_err_cnt", err_cnt_a, 8'd255);
`endif

      // Reset in the middle of a stall
      in_valid_a = 1'b1;
      sel_a      = 3'd3;
      tick();
      out_ready_a = 1'b0;
      sel_a       = 3'd5;
      tick();
      chk1 ("stall_valid", out_valid_a, 1'b1);
      chk32("stall_data",  out_data_a,  32'h1000_0003);
      rst_n = 1'b0;
      tick();
      chk1 ("midrst_valid",    out_valid_a, 1'b0);
      chk32("midrst_data",     out_data_a,  32'h0);
      chk1 ("midrst_in_ready", in_ready_a,  1'b1);
      chk1 ("midrst_sel_err",  sel_err_a,   1'b0);
`ifdef SEL_MUX_ERRCNT_EN
      chk8 ("midrst_err_cnt",  err_cnt_a,   8'd0);
`endif
      in_valid_a = 1'b0;
      rst_n      = 1'b1;
      tick();

      // Narrow configuration: 3 channels of 8 bits, 2-bit select
      out_ready_b = 1'b1;
      in_valid_b  = 1'b1;
      for (int s = 0; s < 3; s++) begin
         sel_b = 2'(s);
         tick();
         chk8 ("nar_data",  out_data_b,  8'hA0 + 8'(s));
         chk1 ("nar_valid", out_valid_b, 1'b1);
         chk1 ("nar_err",   sel_err_b,   1'b0);
      end
      sel_b = 2'd3;
      tick();
      chk1 ("nar_oor_err",   sel_err_b,   1'b1);
      chk1 ("nar_oor_valid", out_valid_b, 1'b0);
      chk8 ("nar_oor_data",  out_data_b,  8'hA2);
      in_valid_b = 1'b0;
      tick();
      chk1 ("nar_err_clear", sel_err_b, 1'b0);
`ifdef SEL_MUX_ERRCNT_EN
      chk8 ("nar_err_cnt", err_cnt_b, 8'd1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
